// File: rtl/pcx2mb_credit_tracker_if.sv
// -----------------------------------------------------------------------------
// pcx2mb_credit_tracker_if
//   Bundles the request/grant strobes and status outputs of the PCX-to-MicroBlaze
//   credit tracker.
//
//   Handshake semantics: there is no valid/ready pair. pcx_req_pa, pcx_req_px,
//   pcx_atom_px and pcx_grant_px are single-cycle strobes that are sampled on
//   every posedge rclk, and the tracker never applies backpressure. The core
//   reads request_mask_pa, and resends a request whenever drop_pa pulses.
//
//   master modport : core side (drives requests/grants, reads status)
//   slave modport  : tracker side
//   cnt_dbg        : flattened per-destination counters, dest i at [i*CW +: CW]
//
//   Optional macro CCX2MB_CREDIT_STATS_EN adds stat_drop_cnt and stat_hwm.
// -----------------------------------------------------------------------------
interface pcx2mb_credit_tracker_if #(
  parameter int NUM_DEST   = 5,
  parameter int CREDIT_MAX = 2
);
  localparam int CW = $clog2(CREDIT_MAX + 1);

  logic [NUM_DEST-1:0]    pcx_req_pa;
  logic [NUM_DEST-1:0]    pcx_req_px;
  logic                   pcx_atom_px;
  logic [NUM_DEST-1:0]    pcx_grant_px;
  logic [NUM_DEST-1:0]    request_mask_pa;
  logic [NUM_DEST-1:0]    drop_pa;
  logic [NUM_DEST-1:0]    err_underflw;
  logic [NUM_DEST*CW-1:0] cnt_dbg;

`ifdef CCX2MB_CREDIT_STATS_EN
  logic [15:0]            stat_drop_cnt;
  logic [NUM_DEST*CW-1:0] stat_hwm;

  modport master (
    output pcx_req_pa, pcx_req_px, pcx_atom_px, pcx_grant_px,
    input  request_mask_pa, drop_pa, err_underflw, cnt_dbg,
    input  stat_drop_cnt, stat_hwm
  );

  modport slave (
    input  pcx_req_pa, pcx_req_px, pcx_atom_px, pcx_grant_px,
    output request_mask_pa, drop_pa, err_underflw, cnt_dbg,
    output stat_drop_cnt, stat_hwm
  );
`else
  modport master (
    output pcx_req_pa, pcx_req_px, pcx_atom_px, pcx_grant_px,
    input  request_mask_pa, drop_pa, err_underflw, cnt_dbg
  );

  modport slave (
    input  pcx_req_pa, pcx_req_px, pcx_atom_px, pcx_grant_px,
    output request_mask_pa, drop_pa, err_underflw, cnt_dbg
  );
`endif
endinterface

// File: rtl/pcx2mb_credit_tracker.sv
// -----------------------------------------------------------------------------
// pcx2mb_credit_tracker
//   Per-destination link-credit tracker for the PCX-to-MicroBlaze bridge. Each
//   of the NUM_DEST destinations has one saturating outstanding-transaction
//   counter (0..CREDIT_MAX).
//
//   Ports:
//     rclk   : core clock, all state updates on posedge
//     reset  : synchronous, active-high
//     bus    : pcx2mb_credit_tracker_if.slave
//       pcx_req_pa[i]      request to dest i in PA (increment)
//       pcx_req_px[i]      PX request to dest i, counts only with pcx_atom_px
//       pcx_atom_px        PX request is atomic
//       pcx_grant_px[i]    grant for dest i (decrement)
//       request_mask_pa[i] dest i counter at CREDIT_MAX (decoded, no flop)
//       drop_pa[i]         registered 1-cycle pulse: increment lost at limit
//       err_underflw[i]    sticky: grant seen with counter at 0
//       cnt_dbg            flattened counters for observation
//
//   Optional macro CCX2MB_CREDIT_STATS_EN adds stat_drop_cnt (saturating total
//   of drop events) and stat_hwm (per-destination high-water mark).
// -----------------------------------------------------------------------------
module pcx2mb_credit_tracker #(
  parameter int NUM_DEST   = 5,
  parameter int CREDIT_MAX = 2
) (
  input  logic                    rclk,
  input  logic                    reset,
  pcx2mb_credit_tracker_if.slave  bus
);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_MAX);

  logic [CW-1:0]       cnt_q [NUM_DEST];
  logic [CW-1:0]       cnt_d [NUM_DEST];
  logic [NUM_DEST-1:0] inc;
  logic [NUM_DEST-1:0] dec;
  logic [NUM_DEST-1:0] drop_d;
  logic [NUM_DEST-1:0] err_set;
  logic [NUM_DEST-1:0] drop_q;
  logic [NUM_DEST-1:0] err_q;

  // Next-state per destination. A simultaneous inc and dec nets to zero and
  // takes priority, so it never drops or underflows even at the bounds.
  always_comb begin
    inc     = '0;
    dec     = '0;
    drop_d  = '0;
    err_set = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      cnt_d[i] = cnt_q[i];
      // A PA request and an atomic PX request in the same cycle count once.
      inc[i] = bus.pcx_req_pa[i] | (bus.pcx_req_px[i] & bus.pcx_atom_px);
      dec[i] = bus.pcx_grant_px[i];
      if (inc[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_MAX) drop_d[i] = 1'b1;
        else                     cnt_d[i]  = cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) err_set[i] = 1'b1;
        else                cnt_d[i]   = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DEST; i++) cnt_q[i] <= '0;
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) cnt_q[i] <= cnt_d[i];
      drop_q <= drop_d;
      err_q  <= err_q | err_set;
    end
  end

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_out
    assign bus.request_mask_pa[g]    = (cnt_q[g] == CNT_MAX);
    assign bus.cnt_dbg[g*CW +: CW]   = cnt_q[g];
  end

  assign bus.drop_pa      = drop_q;
  assign bus.err_underflw = err_q;

`ifdef CCX2MB_CREDIT_STATS_EN
  localparam int PW = $clog2(NUM_DEST + 1);

  logic [PW-1:0]  drop_pop;
  logic [16:0]    drop_sum;
  logic [15:0]    drop_cnt_q;
  logic [CW-1:0]  hwm_q [NUM_DEST];

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NUM_DEST; i++) drop_pop = drop_pop + PW'(drop_d[i]);
    drop_sum = {1'b0, drop_cnt_q} + 17'(drop_pop);
  end

  // Counted on the event itself, so the stat updates on the same edge that
  // raises drop_pa. The high-water mark tracks the value the counter takes.
  always_ff @(posedge rclk) begin
    if (reset) begin
      drop_cnt_q <= '0;
      for (int i = 0; i < NUM_DEST; i++) hwm_q[i] <= '0;
    end else begin
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int i = 0; i < NUM_DEST; i++) begin
        if (cnt_d[i] > hwm_q[i]) hwm_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.stat_drop_cnt = drop_cnt_q;
  for (genvar g = 0; g < NUM_DEST; g++) begin : g_hwm
    assign bus.stat_hwm[g*CW +: CW] = hwm_q[g];
  end
`endif

endmodule

// File: tb/tb_pcx2mb_credit_tracker.sv
module tb_pcx2mb_credit_tracker;
  localparam int ND   = 5;
  localparam int CMAX = 2;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int W    = 3*ND + ND*CW;

  // ---------------- clock / reset ----------------
  logic rclk;
  logic reset;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  pcx2mb_credit_tracker_if #(.NUM_DEST(ND), .CREDIT_MAX(CMAX)) bus ();

  pcx2mb_credit_tracker #(.NUM_DEST(ND), .CREDIT_MAX(CMAX)) dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // Plain integer counts and sticky flags, updated per cycle from the rules.
  int  m_cnt [ND];
  bit  m_err [ND];

  // Expected word: {cnt_flat, err, drop, mask}
  logic [W-1:0] exp_q[$];
  int total_checks  = 0;
  int passed_checks = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [ND-1:0] pa, input logic [ND-1:0] px,
                       input logic atom, input logic [ND-1:0] gnt, input logic rst);
    logic [ND-1:0]    e_mask, e_drop, e_err;
    logic [ND*CW-1:0] e_cnt;
    @(negedge rclk);
    reset            = rst;
    bus.pcx_req_pa   = pa;
    bus.pcx_req_px   = px;
    bus.pcx_atom_px  = atom;
    bus.pcx_grant_px = gnt;
    e_drop = '0;
    for (int i = 0; i < ND; i++) begin
      bit up, down;
      up   = pa[i] || (px[i] && atom);
      down = gnt[i];
      if (rst) begin
        m_cnt[i] = 0;
        m_err[i] = 0;
      end else if (up && !down) begin
        if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        else                 e_drop[i] = 1'b1;
      end else if (down && !up) begin
        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        else              m_err[i] = 1;
      end
    end
    for (int i = 0; i < ND; i++) begin
      e_mask[i] = (m_cnt[i] == CMAX);
      e_err[i]  = m_err[i];
      e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    exp_q.push_back({e_cnt, e_err, e_drop, e_mask});
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  initial begin
    forever begin
      @(posedge rclk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("request_mask_pa", cyc, 32'(bus.request_mask_pa), 32'(e[ND-1:0]));
        check("drop_pa",         cyc, 32'(bus.drop_pa),         32'(e[2*ND-1:ND]));
        check("err_underflw",    cyc, 32'(bus.err_underflw),    32'(e[3*ND-1:2*ND]));
        check("count",           cyc, 32'(bus.cnt_dbg),         32'(e[W-1:3*ND]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.pcx_req_pa   = '0;
    bus.pcx_req_px   = '0;
    bus.pcx_atom_px  = 1'b0;
    bus.pcx_grant_px = '0;
    for (int i = 0; i < ND; i++) begin
      m_cnt[i] = 0;
      m_err[i] = 0;
    end

    // reset for two cycles
    drive('0, '0, 1'b0, '0, 1'b1);
    drive('0, '0, 1'b0, '0, 1'b1);

    // dest 0 fills to the limit, mask follows one cycle later
    drive(5'b00001, '0, 1'b0, '0, 1'b0);
    drive(5'b00001, '0, 1'b0, '0, 1'b0);
    idle();

    // dest 2 overfilled: single drop pulse, count holds
    drive(5'b00100, '0, 1'b0, '0, 1'b0);
    drive(5'b00100, '0, 1'b0, '0, 1'b0);
    drive(5'b00100, '0, 1'b0, '0, 1'b0);
    idle();
    idle();

    // dest 3 at limit with simultaneous req and grant: hold, no drop
    drive(5'b01000, '0, 1'b0, '0, 1'b0);
    drive(5'b01000, '0, 1'b0, '0, 1'b0);
    drive(5'b01000, '0, 1'b0, 5'b01000, 1'b0);
    idle();

    // dest 4 grant at zero: sticky underflow
    drive('0, '0, 1'b0, 5'b10000, 1'b0);
    idle();
    drive('0, '0, 1'b0, 5'b10000, 1'b0);
    idle();

    // dest 1 PA plus atomic PX counts once, then reset mid-burst
    drive(5'b00010, 5'b00010, 1'b1, '0, 1'b0);
    idle();
    drive(5'b00010, 5'b00010, 1'b1, '0, 1'b0);
    drive(5'b00110, '0, 1'b0, '0, 1'b1);
    idle();

    // non-atomic PX alone does not count
    drive('0, 5'b11111, 1'b0, '0, 1'b0);

    // randomized traffic, occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [ND-1:0] pa, px, gnt;
      pa  = ND'($urandom & $urandom);
      px  = ND'($urandom);
      gnt = ND'($urandom & $urandom);
      drive(pa, px, 1'($urandom_range(0, 3) == 0), gnt, $urandom_range(0, 60) == 0);
    end
    idle();

    // let the monitor drain the last expectation
    @(posedge rclk);
    #3;
    check("scoreboard_drained", cyc, 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
